// File: rtl/comm_pkg.sv
// Shared constants and state encoding for the host command framer.
// SOF, command codes and parser states live here.
package comm_pkg;

  localparam logic [7:0] SOF      = 8'h55;
  localparam logic [7:0] CMD_WORK = 8'h01;
  localparam logic [7:0] CMD_PING = 8'h02;
  localparam logic [7:0] CMD_STOP = 8'h03;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_PAYLOAD,
    S_CSUM
  } state_e;

endpackage

// File: rtl/comm_timeout_counter.sv
// Inter-byte idle timer for the frame parser.
// Pulses expired while idle count sits at timeout_cycles-1.
module comm_timeout_counter #(
  parameter int unsigned timeout_cycles = 750000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam logic [23:0] LAST = 24'(timeout_cycles - 1);

  logic [23:0] cnt_q, cnt_d;

  // a byte in the expiry cycle wins over the timeout
  assign expired = enable && !clear && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 24'd1;
    if (clear || !enable || expired) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/comm_frame_parser.sv
// UART byte stream framer: SOF/CMD/payload/CSUM with XOR check.
// Emits work word plus stop/ping pulses; drops bad or stalled frames.
module comm_frame_parser
  import comm_pkg::*;
#(
  parameter int unsigned comm_clk_frequency = 75000000,
  parameter int unsigned payload_bytes      = 80,
  parameter int unsigned timeout_cycles     = comm_clk_frequency / 100
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rx_new_byte,
  input  logic [7:0]                 rx_byte,
  output logic [8*payload_bytes-1:0] work_data,
  output logic                       work_valid,
  output logic                       stop_pulse,
  output logic                       ping_pulse,
  output logic                       frame_err,
  output logic                       timeout_err
);

  localparam int W = 8 * payload_bytes;
  localparam logic [6:0] LASTCNT = 7'(payload_bytes - 1);

  state_e       state_q, state_d;
  logic [W-1:0] stg_q, stg_d;
  logic [W-1:0] wd_q, wd_d;
  logic [W+7:0] shf;
  logic [7:0]   xor_q, xor_d;
  logic [7:0]   cmd_q, cmd_d;
  logic [6:0]   cnt_q, cnt_d;
  logic         wv_q, wv_d;
  logic         sp_q, sp_d;
  logic         pp_q, pp_d;
  logic         fe_q, fe_d;
  logic         te_q, te_d;
  logic         tmr_en, tmr_exp;
  logic         is_work, is_short;

  assign tmr_en   = (state_q != S_IDLE);
  assign is_work  = (rx_byte == CMD_WORK);
  assign is_short = (rx_byte == CMD_PING) || (rx_byte == CMD_STOP);
  assign shf      = {rx_byte, stg_q};

  comm_timeout_counter #(
    .timeout_cycles(timeout_cycles)
  ) u_tmo (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (tmr_en),
    .clear  (rx_new_byte),
    .expired(tmr_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (tmr_exp) begin
      state_d = S_IDLE;
    end else if (rx_new_byte) begin
      unique case (state_q)
        S_IDLE: if (rx_byte == SOF) state_d = S_CMD;
        S_CMD: begin
          unique case (1'b1)
            is_work:  state_d = S_PAYLOAD;
            is_short: state_d = S_CSUM;
            default:  state_d = S_IDLE;
          endcase
        end
        S_PAYLOAD: if (cnt_q == LASTCNT) state_d = S_CSUM;
        S_CSUM:    state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    stg_d = stg_q;
    wd_d  = wd_q;
    xor_d = xor_q;
    cmd_d = cmd_q;
    cnt_d = cnt_q;
    wv_d  = 1'b0;
    sp_d  = 1'b0;
    pp_d  = 1'b0;
    fe_d  = 1'b0;
    te_d  = 1'b0;
    if (tmr_exp) begin
      te_d  = 1'b1;
      stg_d = '0;
    end else if (rx_new_byte) begin
      unique case (state_q)
        S_CMD: begin
          xor_d = rx_byte;
          cmd_d = rx_byte;
          cnt_d = '0;
          fe_d  = !(is_work || is_short);
        end
        S_PAYLOAD: begin
          stg_d = shf[W+7:8];
          xor_d = xor_q ^ rx_byte;
          cnt_d = cnt_q + 7'd1;
        end
        S_CSUM: begin
          if (rx_byte == xor_q) begin
            unique case (1'b1)
              (cmd_q == CMD_WORK): begin
                wd_d = stg_q;
                wv_d = 1'b1;
              end
              (cmd_q == CMD_PING): pp_d = 1'b1;
              default:             sp_d = 1'b1;
            endcase
          end else begin
            fe_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_q <= '0;
      wd_q  <= '0;
      xor_q <= '0;
      cmd_q <= '0;
      cnt_q <= '0;
      wv_q  <= 1'b0;
      sp_q  <= 1'b0;
      pp_q  <= 1'b0;
      fe_q  <= 1'b0;
      te_q  <= 1'b0;
    end else begin
      stg_q <= stg_d;
      wd_q  <= wd_d;
      xor_q <= xor_d;
      cmd_q <= cmd_d;
      cnt_q <= cnt_d;
      wv_q  <= wv_d;
      sp_q  <= sp_d;
      pp_q  <= pp_d;
      fe_q  <= fe_d;
      te_q  <= te_d;
    end
  end

  assign work_data   = wd_q;
  assign work_valid  = wv_q;
  assign stop_pulse  = sp_q;
  assign ping_pulse  = pp_q;
  assign frame_err   = fe_q;
  assign timeout_err = te_q;

endmodule
